redmule_x_scheduler: RTL and testbench

Sequencer for the RedMulE X operand buffer. It tiles an X matrix of rows x cols elements into buffer-sized tiles of W rows by TOT_DEPTH columns. For each tile it does three things: loads rows from the streamer under a valid/ready handshake, primes the buffer with a block shift, and feeds the engine through h_shift/d_shift pulses paced by engine consume requests. It sits between the controller/streamer and the X buffer and drives the buffer's per-tile control bundle (load, shifts, leftovers, slots, clear).

---
 rtl/redmule_x_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_redmule_x_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_x_scheduler.sv
// -----------------------------------------------------------------------------
// redmule_x_scheduler
// Sequencer for the RedMulE X operand buffer. The X matrix (rows x cols) is cut
// into tiles of W rows by TOT_DEPTH (= H*D) columns; the column tile is the
// inner loop. Per tile: load rows from the streamer, prime the buffer with one
// block shift, then feed the engine with h_shift/d_shift pulses on demand.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous abort back to IDLE (highest priority)
//   start_i, rows_i, cols_i  job start and matrix size (latched in IDLE)
//   x_valid_i / x_ready_o    streamer row-beat handshake
//   consume_i / x_avail_o    engine column request / feedable data present
//   buf_full_i, buf_empty_i  X buffer status
//   load_o, d_shift_o, blck_shift_o, h_shift_o, clear_o   X buffer controls
//   rows_lftovr_o, cols_lftovr_o, slots_o                 current tile geometry
//   busy_o, done_o           activity flag and job completion pulse
//
// Optional feature (macro REDMULE_X_SCHED_PERF_EN): adds stall_cnt_o[31:0], a
// saturating count of LOAD cycles without x_valid_i plus FEED cycles without
// consume_i, cleared when a job is accepted.
// -----------------------------------------------------------------------------
module redmule_x_scheduler #(
  parameter int W     = 12,
  parameter int H     = 4,
  parameter int D     = 4,
  parameter int CFG_W = 16,
  localparam int TOT_DEPTH = H * D,
  localparam int RW        = $clog2(W) + 1,
  localparam int CW        = $clog2(TOT_DEPTH) + 1,
  localparam int SW        = $clog2(D) + 1,
  localparam int HW        = (H > 1) ? $clog2(H) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CFG_W-1:0] rows_i,
  input  logic [CFG_W-1:0] cols_i,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic             consume_i,
  output logic             x_avail_o,
  input  logic             buf_full_i,
  input  logic             buf_empty_i,
  output logic             load_o,
  output logic             d_shift_o,
  output logic             blck_shift_o,
  output logic             h_shift_o,
  output logic             clear_o,
  output logic [RW-1:0]    rows_lftovr_o,
  output logic [CW-1:0]    cols_lftovr_o,
  output logic [SW-1:0]    slots_o,
  output logic             busy_o,
  output logic             done_o
`ifdef REDMULE_X_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PRIME, FEED, ADV, NEXT, FIN, ZDONE
  } state_e;

  state_e state_q, state_d;

  logic [CFG_W-1:0] rows_q, cols_q, rt_q, ct_q, nxt_rt, nxt_ct;
  logic             last_rt_q, last_ct_q;
  logic [RW-1:0]    rlo_q, row_cnt, rlim;
  logic [CW-1:0]    clo_q;
  logic [SW-1:0]    slots_q, slot_cnt;
  logic [HW-1:0]    h_cnt;

  logic             x_ready, x_avail, load_beat, h_beat;
  logic             row_last, h_wrap, slot_more, last_tile;

  logic [CFG_W-1:0] g_rows, g_cols, g_rt, g_ct;
  logic [31:0]      rem_rows, rem_cols;
  logic             g_last_rt, g_last_ct;
  logic [RW-1:0]    g_rlo;
  logic [CW-1:0]    g_clo;
  logic [SW-1:0]    g_slots;

  // Handshake qualifiers. A full buffer refuses further beats, and an empty
  // buffer has nothing to shift towards the engine.
  assign x_ready   = (state_q == LOAD) && !buf_full_i;
  assign x_avail   = (state_q == FEED) && !buf_empty_i;
  assign load_beat = x_ready && x_valid_i;
  assign h_beat    = x_avail && consume_i;

  assign rlim      = (rlo_q == '0) ? RW'(W) : rlo_q;
  assign row_last  = (row_cnt + RW'(1)) == rlim;
  assign h_wrap    = (h_cnt == HW'(H - 1));
  assign slot_more = (slot_cnt + SW'(1)) < slots_q;
  assign last_tile = last_rt_q && last_ct_q;

  assign nxt_ct = last_ct_q ? '0 : ct_q + CFG_W'(1);
  assign nxt_rt = last_ct_q ? rt_q + CFG_W'(1) : rt_q;

  // Geometry of the tile about to start: the first tile when a job is
  // accepted in IDLE, otherwise the successor of the current tile. The
  // remaining extent decides whether it is the last tile and its leftover.
  always_comb begin
    g_rows = rows_q;
    g_cols = cols_q;
    g_rt   = nxt_rt;
    g_ct   = nxt_ct;
    if (state_q == IDLE) begin
      g_rows = rows_i;
      g_cols = cols_i;
      g_rt   = '0;
      g_ct   = '0;
    end
    rem_rows  = 32'(g_rows) - 32'(g_rt) * W;
    rem_cols  = 32'(g_cols) - 32'(g_ct) * TOT_DEPTH;
    g_last_rt = (rem_rows <= W);
    g_last_ct = (rem_cols <= TOT_DEPTH);
    g_rlo     = '0;
    g_clo     = '0;
    if (g_last_rt && (rem_rows != W)) g_rlo = RW'(rem_rows);
    if (g_last_ct && (rem_cols != TOT_DEPTH)) g_clo = CW'(rem_cols);
    g_slots = SW'(D);
    if (g_clo != '0) g_slots = SW'((32'(g_clo) + H - 1) / H);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear_i overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (rows_i == '0 || cols_i == '0) ? ZDONE : LOAD;
      LOAD:  if ((load_beat && row_last) || buf_full_i) state_d = PRIME;
      PRIME: state_d = FEED;
      FEED: begin
        if (h_beat && h_wrap) begin
          if (slot_more)      state_d = ADV;
          else if (last_tile) state_d = FIN;
          else                state_d = NEXT;
        end
      end
      ADV:     state_d = FEED;
      NEXT:    state_d = LOAD;
      FIN:     state_d = IDLE;
      ZDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Outputs; pulses are suppressed in an abort cycle so only clear_o remains
  always_comb begin
    x_ready_o     = x_ready;
    x_avail_o     = x_avail;
    load_o        = load_beat && !clear_i;
    h_shift_o     = h_beat && !clear_i;
    blck_shift_o  = (state_q == PRIME) && !clear_i;
    d_shift_o     = (state_q == ADV) && !clear_i;
    clear_o       = clear_i || (state_q == NEXT) || (state_q == FIN);
    done_o        = ((state_q == FIN) || (state_q == ZDONE)) && !clear_i;
    busy_o        = (state_q != IDLE);
    rows_lftovr_o = rlo_q;
    cols_lftovr_o = clo_q;
    slots_o       = slots_q;
  end

  // Configuration, tile indices, geometry and the load/feed counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_q <= '0; cols_q <= '0; rt_q <= '0; ct_q <= '0;
      last_rt_q <= 1'b0; last_ct_q <= 1'b0;
      rlo_q <= '0; clo_q <= '0; slots_q <= SW'(D);
      row_cnt <= '0; h_cnt <= '0; slot_cnt <= '0;
    end else if (clear_i) begin
      rt_q <= '0; ct_q <= '0;
      last_rt_q <= 1'b0; last_ct_q <= 1'b0;
      rlo_q <= '0; clo_q <= '0; slots_q <= SW'(D);
      row_cnt <= '0; h_cnt <= '0; slot_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rows_q <= rows_i; cols_q <= cols_i;
            rt_q <= '0; ct_q <= '0;
            last_rt_q <= g_last_rt; last_ct_q <= g_last_ct;
            rlo_q <= g_rlo; clo_q <= g_clo; slots_q <= g_slots;
            row_cnt <= '0; h_cnt <= '0; slot_cnt <= '0;
          end
        end
        LOAD: if (load_beat) row_cnt <= row_cnt + RW'(1);
        FEED: begin
          if (h_beat) begin
            if (h_wrap) begin
              h_cnt    <= '0;
              slot_cnt <= slot_cnt + SW'(1);
            end else begin
              h_cnt <= h_cnt + HW'(1);
            end
          end
        end
        NEXT: begin
          rt_q <= nxt_rt; ct_q <= nxt_ct;
          last_rt_q <= g_last_rt; last_ct_q <= g_last_ct;
          rlo_q <= g_rlo; clo_q <= g_clo; slots_q <= g_slots;
          row_cnt <= '0; h_cnt <= '0; slot_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef REDMULE_X_SCHED_PERF_EN
  // Stall counter: starved LOAD cycles plus idle FEED cycles, saturating
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start_i && !clear_i) begin
      stall_q <= '0;
    end else if ((((state_q == LOAD) && !x_valid_i) || ((state_q == FEED) && !consume_i))
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_redmule_x_scheduler.sv
// -----------------------------------------------------------------------------
// tb_redmule_x_scheduler
// Scoreboard bench for redmule_x_scheduler. Each job pushes its expected
// sequence of buffer-control events (with tile geometry) into a queue; a
// monitor thread pops and compares whenever the DUT issues any control pulse.
// Per-job pulse totals are also compared against hand-computed counts.
// -----------------------------------------------------------------------------
module tb_redmule_x_scheduler;

  localparam int W  = 12;
  localparam int H  = 4;
  localparam int D  = 4;
  localparam int TD = H * D;

  localparam logic [5:0] EV_LOAD = 6'b000001;
  localparam logic [5:0] EV_BLCK = 6'b000010;
  localparam logic [5:0] EV_D    = 6'b000100;
  localparam logic [5:0] EV_H    = 6'b001000;
  localparam logic [5:0] EV_CLR  = 6'b010000;
  localparam logic [5:0] EV_DONE = 6'b100000;

  typedef struct {
    logic [5:0] ev;
    logic       chk;
    int         rlo;
    int         clo;
    int         slots;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_i, start_i, x_valid_i, consume_i, buf_full_i, buf_empty_i;
  logic [15:0] rows_i, cols_i;
  logic        x_ready_o, x_avail_o, load_o, d_shift_o, blck_shift_o, h_shift_o;
  logic        clear_o, busy_o, done_o;
  logic [4:0]  rows_lftovr_o, cols_lftovr_o;
  logic [2:0]  slots_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tot_load = 0, tot_h = 0, tot_d = 0, tot_done = 0, tot_clr = 0, tot_ready = 0;

  redmule_x_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
    .rows_i(rows_i), .cols_i(cols_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .consume_i(consume_i), .x_avail_o(x_avail_o), .buf_full_i(buf_full_i),
    .buf_empty_i(buf_empty_i), .load_o(load_o), .d_shift_o(d_shift_o),
    .blck_shift_o(blck_shift_o), .h_shift_o(h_shift_o), .clear_o(clear_o),
    .rows_lftovr_o(rows_lftovr_o), .cols_lftovr_o(cols_lftovr_o), .slots_o(slots_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(logic [5:0] ev, logic chk, int rlo, int clo, int slots);
    exp_t e;
    e.ev = ev; e.chk = chk; e.rlo = rlo; e.clo = clo; e.slots = slots;
    exp_q.push_back(e);
  endtask

  // Reference sequence: tiles row-outer/column-inner, W-row loads, one block
  // shift, H h_shifts per slot with a d_shift between slots, then clear (with
  // done on the final tile). max_h > 0 truncates the job with an abort clear.
  task automatic push_model(int rows, int cols, int max_h);
    int rt_n, ct_n, rlo, clo, slots, rlim, hc;
    logic last;
    hc = 0;
    if (rows == 0 || cols == 0) begin
      push_ev(EV_DONE, 1'b0, 0, 0, 0);
      return;
    end
    rt_n = (rows + W - 1) / W;
    ct_n = (cols + TD - 1) / TD;
    for (int rt = 0; rt < rt_n; rt++) begin
      for (int ct = 0; ct < ct_n; ct++) begin
        rlo   = (rt == rt_n - 1) ? rows % W : 0;
        clo   = (ct == ct_n - 1) ? cols % TD : 0;
        slots = (clo != 0) ? (clo + H - 1) / H : D;
        rlim  = (rlo != 0) ? rlo : W;
        for (int i = 0; i < rlim; i++) push_ev(EV_LOAD, 1'b1, rlo, clo, slots);
        push_ev(EV_BLCK, 1'b1, rlo, clo, slots);
        for (int s = 0; s < slots; s++) begin
          for (int h = 0; h < H; h++) begin
            push_ev(EV_H, 1'b1, rlo, clo, slots);
            hc++;
            if (hc == max_h) begin
              push_ev(EV_CLR, 1'b0, 0, 0, 0);
              return;
            end
          end
          if (s < slots - 1) push_ev(EV_D, 1'b1, rlo, clo, slots);
        end
        last = (rt == rt_n - 1) && (ct == ct_n - 1);
        push_ev(last ? (EV_CLR | EV_DONE) : EV_CLR, 1'b1, rlo, clo, slots);
      end
    end
  endtask

  // Runs one job and compares the pulse totals against the given counts
  task automatic apply_stimulus(input int rows, input int cols, input bit toggle,
                                input int max_h, input int e_load, input int e_h,
                                input int e_d, input int e_done, input int e_clr,
                                input int e_ready);
    int s_load, s_h, s_d, s_done, s_clr, s_ready, h_seen;
    bit finished, aborted;
    s_load = tot_load; s_h = tot_h; s_d = tot_d;
    s_done = tot_done; s_clr = tot_clr; s_ready = tot_ready;
    h_seen = 0; finished = 0; aborted = 0;
    $display("[TB] job rows=%0d cols=%0d toggle=%0d abort_after=%0d", rows, cols, toggle, max_h);
    push_model(rows, cols, max_h);
    @(posedge clk); #1;
    rows_i = 16'(rows); cols_i = 16'(cols);
    x_valid_i = 1'b1; consume_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && (rows == 0 || cols == 0)) check_output("zero_done_latency", done_o, 1);
      if (h_shift_o) h_seen++;
      if (max_h > 0 && h_seen == max_h && !aborted) begin
        aborted = 1;
        @(posedge clk); #1;
        clear_i = 1'b1; consume_i = 1'b0;
        @(posedge clk); #1;
        clear_i = 1'b0; consume_i = 1'b1;
        @(negedge clk);
        check_output("busy_after_clear", busy_o, 0);
      end
      if (!busy_o) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      if (toggle) x_valid_i = ~x_valid_i;
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL job_timeout: busy_o still %0d, expected 0", busy_o);
    end
    check_output("load_count",  tot_load  - s_load,  e_load);
    check_output("hshift_count", tot_h    - s_h,     e_h);
    check_output("dshift_count", tot_d    - s_d,     e_d);
    check_output("done_count",  tot_done  - s_done,  e_done);
    check_output("clear_count", tot_clr   - s_clr,   e_clr);
    check_output("ready_cycles", tot_ready - s_ready, e_ready);
    check_output("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    x_valid_i = 1'b1;
  endtask

  // Monitor: any control pulse is one scoreboard event
  task automatic monitor();
    logic [5:0] ev;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (x_ready_o) tot_ready++;
        ev = {done_o, clear_o, h_shift_o, d_shift_o, blck_shift_o, load_o};
        if (ev != 6'b0) begin
          if (load_o)  tot_load++;
          if (h_shift_o) tot_h++;
          if (d_shift_o) tot_d++;
          if (done_o)  tot_done++;
          if (clear_o) tot_clr++;
          if (load_o) check_output("load_needs_valid", x_valid_i, 1);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL unexpected_event: got %b, expected no event", ev);
          end else begin
            e = exp_q.pop_front();
            check_output("event", 32'(ev), 32'(e.ev));
            if (e.chk) begin
              check_output("rows_lftovr", rows_lftovr_o, e.rlo);
              check_output("cols_lftovr", cols_lftovr_o, e.clo);
              check_output("slots", slots_o, e.slots);
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; x_valid_i = 1'b1;
    consume_i = 1'b1; buf_full_i = 1'b0; buf_empty_i = 1'b0;
    rows_i = '0; cols_i = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_output("reset_busy", busy_o, 0);
    check_output("reset_ready", x_ready_o, 0);
    check_output("reset_pulses",
                 {load_o, d_shift_o, blck_shift_o, h_shift_o, clear_o, done_o, x_avail_o}, 0);
    check_output("reset_rows_lftovr", rows_lftovr_o, 0);
    check_output("reset_cols_lftovr", cols_lftovr_o, 0);
    check_output("reset_slots", slots_o, 4);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apply_stimulus(12, 16, 1'b0, -1, 12, 16, 3, 1, 1, 12);
    apply_stimulus(14, 16, 1'b0, -1, 14, 32, 6, 1, 2, 14);
    apply_stimulus(12, 20, 1'b0, -1, 24, 20, 3, 1, 2, 24);
    apply_stimulus(12, 16, 1'b1, -1, 12, 16, 3, 1, 1, 23);
    apply_stimulus(12, 16, 1'b0,  5, 12,  5, 1, 0, 1, 12);
    apply_stimulus(12, 16, 1'b0, -1, 12, 16, 3, 1, 1, 12);
    apply_stimulus(0,  16, 1'b0, -1,  0,  0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
